// File: rtl/dff4_ce.sv
// dff4_ce: WIDTH-bit D register. It loads d on the rising clk edge when ce is
// high and holds its value otherwise. clr is an asynchronous, active-low clear
// that forces q to RESET_VAL.
// Storage element for datapath latching and pipeline holding.

module dff4_ce #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register with async clear; clr takes priority over the enable path.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= RESET_VAL;
        end else if (ce) begin
            // NOTE: non-blocking assignment keeps every flop sampling pre-edge values; ce acts as a mux/flop enable, never a gated clock.
            q <= d;
        end
    end

endmodule

// File: tb/tb_dff4_ce.sv
// Directed testbench for dff4_ce. It checks clear, clear priority, load, hold,
// async clear in mid-cycle, back-to-back loads and immunity to activity
// between clock edges.

`timescale 1ns/1ps

module tb_dff4_ce;

    logic       clk;
    logic       clr;
    logic       ce;
    logic [3:0] d;
    logic [3:0] q;

    int checks   = 0;
    int failures = 0;

    dff4_ce #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk (clk),
        .clr (clr),
        .ce  (ce),
        .d   (d),
        .q   (q)
    );

    // 20 ns period, first rising edge at 10 ns.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic test_reset();
        clr = 1'b1;
        ce  = 1'b0;
        d   = 4'b0000;
        #2;
        clr = 1'b0;
        ce  = 1'b1;
        d   = 4'b1111;
        #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL reset_immediate: q=%b expected=%b", q, 4'b0000);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL reset_across_edge: q=%b expected=%b", q, 4'b0000);
        end
        @(negedge clk);
    endtask

    task automatic test_clear_overrides_enable();
        ce = 1'b0;
        d  = 4'b1010;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL clear_ce0: q=%b expected=%b", q, 4'b0000);
        end
        @(negedge clk);
        ce = 1'b1;
        d  = 4'b0110;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL clear_ce1: q=%b expected=%b", q, 4'b0000);
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        clr = 1'b1;
        ce  = 1'b1;
        d   = 4'b0101;
        #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL release_keeps_reset: q=%b expected=%b", q, 4'b0000);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b0101) begin
            failures++;
            $display("FAIL load: q=%b expected=%b", q, 4'b0101);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        ce = 1'b0;
        d  = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (q !== 4'b0101) begin
                failures++;
                $display("FAIL hold_edge%0d: q=%b expected=%b", i, q, 4'b0101);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_async_clear();
        // The falling edge lies halfway between two rising edges.
        clr = 1'b0;
        #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL async_clear_midcycle: q=%b expected=%b", q, 4'b0000);
        end
        @(negedge clk);
        clr = 1'b1;
        ce  = 1'b1;
        d   = 4'b1100;
        #1;
        checks++;
        if (q !== 4'b0000) begin
            failures++;
            $display("FAIL async_release_no_load: q=%b expected=%b", q, 4'b0000);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b1100) begin
            failures++;
            $display("FAIL async_release_load: q=%b expected=%b", q, 4'b1100);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        ce = 1'b1;
        d  = 4'b0011;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b0011) begin
            failures++;
            $display("FAIL b2b_first: q=%b expected=%b", q, 4'b0011);
        end
        @(negedge clk);
        d = 4'b1001;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b1001) begin
            failures++;
            $display("FAIL b2b_second: q=%b expected=%b", q, 4'b1001);
        end
        // Toggle d between edges and confirm that q stays put until the edge.
        @(negedge clk);
        d = 4'b0110;
        #3;
        checks++;
        if (q !== 4'b1001) begin
            failures++;
            $display("FAIL d_toggle_a: q=%b expected=%b", q, 4'b1001);
        end
        d = 4'b1111;
        #3;
        checks++;
        if (q !== 4'b1001) begin
            failures++;
            $display("FAIL d_toggle_b: q=%b expected=%b", q, 4'b1001);
        end
        d = 4'b1010;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b1010) begin
            failures++;
            $display("FAIL d_toggle_load: q=%b expected=%b", q, 4'b1010);
        end
        @(negedge clk);
    endtask

    task automatic test_enable_timing();
        // A ce pulse that falls before the edge must not cause a load.
        ce = 1'b0;
        d  = 4'b0111;
        #4;
        ce = 1'b1;
        #1;
        checks++;
        if (q !== 4'b1010) begin
            failures++;
            $display("FAIL ce_pulse_no_comb: q=%b expected=%b", q, 4'b1010);
        end
        #3;
        ce = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b1010) begin
            failures++;
            $display("FAIL ce_pulse_no_load: q=%b expected=%b", q, 4'b1010);
        end
        @(negedge clk);
        ce = 1'b1;
        d  = 4'b1000;
        @(posedge clk); #1;
        checks++;
        if (q !== 4'b1000) begin
            failures++;
            $display("FAIL ce_final_load: q=%b expected=%b", q, 4'b1000);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clear_overrides_enable();
        test_load();
        test_hold();
        test_async_clear();
        test_back_to_back();
        test_enable_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
